iobuf_bidir_ctrl: RTL

Fabric-side controller for a bank of bidirectional pad buffers: one IOBUF per bit, with T active-high tristate, I driven to the pad, and O read from the pad. It converts a single-port request stream of writes and reads into cycle-accurate per-bit `PAD_T`/`PAD_I` control and `PAD_O` capture. It inserts programmable bus-turnaround guard cycles so this end and the far end never drive the shared lines simultaneously. It sits between a fabric master and an HSTL/DCI bidirectional pad bank.

---
 rtl/iobuf_bidir_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/iobuf_bidir_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : iobuf_bidir_ctrl
//  Purpose  : Fabric-side controller for a bank of bidirectional pad buffers
//             (one IOBUF per bit). Turns a single-port write/read request
//             stream into per-bit PAD_T / PAD_I control and PAD_O capture.
//             Programmable turnaround guard cycles keep this end and the far
//             end from driving the shared lines at the same time.
//  Ports    : CLK, RST_N            - clock, async active-low reset
//             REQ_VALID/WRITE/DATA  - request stream (write drives, read samples)
//             REQ_READY             - request accepted on VALID & READY edge
//             RSP_VALID/RSP_DATA    - one-cycle pulse with captured pad data
//             PAD_I, PAD_T, PAD_O   - IOBUF I, T (1 = high-Z), O
//             BUS_DRIVEN            - this end is driving the bus (~PAD_T[0])
//  Revision : 1.0 - initial release
// ============================================================================
module iobuf_bidir_ctrl #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned TURN_CYCLES  = 1,
    parameter int unsigned SAMPLE_DELAY = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_VALID,
    input  logic             REQ_WRITE,
    input  logic [WIDTH-1:0] REQ_DATA,
    output logic             REQ_READY,
    output logic             RSP_VALID,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic [WIDTH-1:0] PAD_I,
    output logic [WIDTH-1:0] PAD_T,
    input  logic [WIDTH-1:0] PAD_O,
    output logic             BUS_DRIVEN
);

    // One down-counter is shared by TURN and SAMPLE, so it is sized for the
    // longer of the two intervals.
    localparam int unsigned c_max_cycles =
        (TURN_CYCLES > SAMPLE_DELAY) ? TURN_CYCLES : SAMPLE_DELAY;
    localparam int unsigned c_cnt_w = $clog2(c_max_cycles + 1);

    // Counter is loaded with (N-1) on entry and the state exits on the edge
    // where it reads zero, giving exactly N cycles in the state.
    localparam logic [c_cnt_w-1:0] c_turn_load   = c_cnt_w'(TURN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_sample_load = c_cnt_w'(SAMPLE_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_TURN   = 2'd2,
        ST_SAMPLE = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_pend_rd;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [WIDTH-1:0]   r_pad_i;
    logic [WIDTH-1:0]   r_pad_t;

    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               w_pend_rd_nxt;
    logic               w_req_ready_nxt;
    logic               w_rsp_valid_nxt;
    logic [WIDTH-1:0]   w_rsp_data_nxt;
    logic [WIDTH-1:0]   w_pad_i_nxt;
    logic [WIDTH-1:0]   w_pad_t_nxt;
    logic               w_accept;

    // Acceptance uses the registered READY, which is only ever high in IDLE
    // and DRIVE, so a request can never land in TURN or SAMPLE.
    assign w_accept = REQ_VALID & r_req_ready;

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_pend_rd_nxt   = r_pend_rd;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_data_nxt  = r_rsp_data;
        w_pad_i_nxt     = r_pad_i;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (REQ_WRITE) begin
                        w_state_nxt = ST_DRIVE;
                        w_pad_i_nxt = REQ_DATA;
                    end else begin
                        w_state_nxt = ST_SAMPLE;
                        w_cnt_nxt   = c_sample_load;
                    end
                end
            end

            ST_DRIVE: begin
                if (w_accept && REQ_WRITE) begin
                    // Back-to-back write: bus stays driven, data updates.
                    w_pad_i_nxt = REQ_DATA;
                end else begin
                    // Read or no request: release now and guard before the
                    // far end may drive.
                    w_state_nxt   = ST_TURN;
                    w_cnt_nxt     = c_turn_load;
                    w_pend_rd_nxt = w_accept;
                end
            end

            ST_TURN: begin
                if (r_cnt == '0) begin
                    if (r_pend_rd) begin
                        w_state_nxt = ST_SAMPLE;
                        w_cnt_nxt   = c_sample_load;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end

            ST_SAMPLE: begin
                if (r_cnt == '0) begin
                    // Capture, then always guard so the far end can release.
                    w_rsp_data_nxt  = PAD_O;
                    w_rsp_valid_nxt = 1'b1;
                    w_pend_rd_nxt   = 1'b0;
                    w_state_nxt     = ST_TURN;
                    w_cnt_nxt       = c_turn_load;
                end else begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end
            end

            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = '0;
                w_pend_rd_nxt = 1'b0;
            end
        endcase

        // Outputs are registered, so they are decoded from the next state.
        w_req_ready_nxt = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DRIVE);
        w_pad_t_nxt     = {WIDTH{w_state_nxt != ST_DRIVE}};
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_pend_rd   <= 1'b0;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_pad_i     <= '0;
            r_pad_t     <= '1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pend_rd   <= w_pend_rd_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_pad_i     <= w_pad_i_nxt;
            r_pad_t     <= w_pad_t_nxt;
        end
    end

    assign REQ_READY  = r_req_ready;
    assign RSP_VALID  = r_rsp_valid;
    assign RSP_DATA   = r_rsp_data;
    assign PAD_I      = r_pad_i;
    assign PAD_T      = r_pad_t;
    assign BUS_DRIVEN = ~r_pad_t[0];

endmodule
`default_nettype wire
